// File: rtl/uart_tx_sched_if.sv
// Byte-source handshake bundle: N_REQ producers offer bytes, the scheduler strobes acceptance.
interface uart_tx_sched_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]   req_valid;
   logic [8*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]   req_ready;

   modport master (output req_valid, output req_data, input req_ready);
   modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one 8N1 UART tx line among N_REQ byte sources.
// A frame is START, 8 data bits LSB first, STOP; every bit lasts F/BAUD clocks.
module uart_tx_sched #(
   parameter int BAUD  = 9600,
   parameter int F     = 50000000,
   parameter int N_REQ = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   uart_tx_sched_if.slave           req,
   output logic                     tx,
   output logic                     busy,
   output logic [$clog2(N_REQ)-1:0] grant_id
);

   localparam int DIV = F / BAUD;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int GW  = $clog2(N_REQ);
   localparam logic [CW-1:0] LAST_CNT = CW'(DIV - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_d;
   logic [CW-1:0] baud_cnt, baud_cnt_d;
   logic [2:0]    bit_idx, bit_idx_d;
   logic [7:0]    frame_q, frame_d;
   logic          tx_d;
   logic [GW-1:0] grant_d;
   logic [GW-1:0] ptr, ptr_d;
   logic          found;
   logic [GW-1:0] winner;
   logic [GW-1:0] cand;
   logic          bit_end;

   // First valid source at or after the priority pointer, wrapping mod N_REQ.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = GW'((int'(ptr) + i) % N_REQ);
         if (!found && req.req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   // Gated by rst so no acceptance strobe can appear while reset is held.
   always_comb begin
      req.req_ready = '0;
      if (rst && state == IDLE && found) begin
         req.req_ready[winner] = 1'b1;
      end
   end

   assign bit_end = (baud_cnt == LAST_CNT);
   assign busy    = (state != IDLE);

   always_comb begin
      state_d    = state;
      baud_cnt_d = baud_cnt;
      bit_idx_d  = bit_idx;
      frame_d    = frame_q;
      tx_d       = tx;
      grant_d    = grant_id;
      ptr_d      = ptr;
      case (state)
         IDLE: begin
            baud_cnt_d = '0;
            tx_d       = 1'b1;
            if (found) begin
               frame_d   = req.req_data[8*winner +: 8];
               grant_d   = winner;
               ptr_d     = (winner == GW'(N_REQ - 1)) ? '0 : winner + 1'b1;
               bit_idx_d = '0;
               tx_d      = 1'b0;
               state_d   = START;
            end
         end
         START: begin
            if (bit_end) begin
               baud_cnt_d = '0;
               bit_idx_d  = '0;
               tx_d       = frame_q[0];
               state_d    = DATA;
            end else begin
               baud_cnt_d = baud_cnt + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_cnt_d = '0;
               if (bit_idx == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx + 3'd1;
                  tx_d      = frame_q[3'(bit_idx + 3'd1)];
               end
            end else begin
               baud_cnt_d = baud_cnt + 1'b1;
            end
         end
         STOP: begin
            tx_d = 1'b1;
            if (bit_end) begin
               baud_cnt_d = '0;
               state_d    = IDLE;
            end else begin
               baud_cnt_d = baud_cnt + 1'b1;
            end
         end
         default: begin
            baud_cnt_d = '0;
            tx_d       = 1'b1;
            state_d    = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         frame_q  <= '0;
         tx       <= 1'b1;
         grant_id <= '0;
         ptr      <= '0;
      end else begin
         state    <= state_d;
         baud_cnt <= baud_cnt_d;
         bit_idx  <= bit_idx_d;
         frame_q  <= frame_d;
         tx       <= tx_d;
         grant_id <= grant_d;
         ptr      <= ptr_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched at DIV=10, N_REQ=4: a vector table of frames plus
// hand-written sequences for mid-frame data change, mid-frame reset and long idle.
module tb_uart_tx_sched;

   localparam int F     = 1000;
   localparam int BAUD  = 100;
   localparam int DIV   = 10;
   localparam int N     = 4;
   localparam int FRAME = 10 * DIV;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx;
   logic       busy;
   logic [1:0] grant_id;

   uart_tx_sched_if #(.N_REQ(N)) bus ();

   uart_tx_sched #(.BAUD(BAUD), .F(F), .N_REQ(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (bus),
      .tx       (tx),
      .busy     (busy),
      .grant_id (grant_id)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic       do_reset;
      logic [3:0] valid;
      logic [31:0] data;
      int         exp_win;
      logic [7:0] exp_byte;
      logic       chk_gap;
   } vec_t;

   vec_t vecs [11];

   int n_cmp     = 0;
   int n_fail    = 0;
   int last_xfer = -1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Assumes rst is high on entry so lowering it is a real asynchronous edge.
   task automatic doReset();
      rst = 1'b0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("rst_tx", 32'(tx), 32'd1);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_ready", 32'(bus.req_ready), 32'd0);
      checkOutput("rst_grant", 32'(grant_id), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      last_xfer = -1;
   endtask

   task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d, input string tag, output bit ok);
      bus.req_valid = v;
      bus.req_data  = d;
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
         #1;
         if (bus.req_ready != '0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) checkOutput($sformatf("%s_ready_timeout", tag), 32'(bus.req_ready), 32'd1);
   endtask

   // Checks the strobe, lets the transfer edge pass, and leaves the bench at the
   // negedge of the first START clock.
   task automatic waitTransfer(input int exp_win, input logic chk_gap, input string tag);
      checkOutput($sformatf("%s_ready", tag), 32'(bus.req_ready), 32'(1 << exp_win));
      checkOutput($sformatf("%s_idle_busy", tag), 32'(busy), 32'd0);
      @(negedge clk);
      checkOutput($sformatf("%s_grant", tag), 32'(grant_id), 32'(exp_win));
      checkOutput($sformatf("%s_start_tx", tag), 32'(tx), 32'd0);
      if (chk_gap) checkOutput($sformatf("%s_gap", tag), 32'(cyc - last_xfer), 32'(FRAME + 1));
      last_xfer = cyc;
   endtask

   task automatic runFrame(input logic [7:0] exp_byte, input int chg_cyc, input logic [3:0] chg_v,
                           input logic [31:0] chg_d, input string tag);
      int   bad = 0;
      logic [7:0] got = '0;
      logic expb;
      for (int c = 0; c < FRAME; c++) begin
         if (c < DIV)          expb = 1'b0;
         else if (c < 9 * DIV) expb = exp_byte[(c - DIV) / DIV];
         else                  expb = 1'b1;
         if (tx !== expb || busy !== 1'b1 || bus.req_ready !== '0) bad++;
         if (c >= DIV && c < 9 * DIV && (c % DIV) == DIV / 2) got[(c - DIV) / DIV] = tx;
         if (c == chg_cyc) begin
            bus.req_valid = chg_v;
            bus.req_data  = chg_d;
         end
         @(negedge clk);
      end
      checkOutput($sformatf("%s_byte", tag), 32'(got), 32'(exp_byte));
      checkOutput($sformatf("%s_bad_clocks", tag), 32'(bad), 32'd0);
      checkOutput($sformatf("%s_end_busy", tag), 32'(busy), 32'd0);
      checkOutput($sformatf("%s_end_tx", tag), 32'(tx), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit ok;
      int bad_tx, bad_busy, bad_rdy;

      bus.req_valid = '0;
      bus.req_data  = '0;

      vecs[0]  = '{1'b1, 4'b0100, 32'h00A5_0000, 2, 8'hA5, 1'b0};
      vecs[1]  = '{1'b1, 4'b1111, 32'h4433_2211, 0, 8'h11, 1'b0};
      vecs[2]  = '{1'b0, 4'b1111, 32'h4433_2211, 1, 8'h22, 1'b1};
      vecs[3]  = '{1'b0, 4'b1111, 32'h4433_2211, 2, 8'h33, 1'b1};
      vecs[4]  = '{1'b0, 4'b1111, 32'h4433_2211, 3, 8'h44, 1'b1};
      vecs[5]  = '{1'b0, 4'b1111, 32'h4433_2211, 0, 8'h11, 1'b1};
      vecs[6]  = '{1'b0, 4'b0010, 32'h0000_5A00, 1, 8'h5A, 1'b1};
      vecs[7]  = '{1'b0, 4'b1001, 32'hC300_003C, 3, 8'hC3, 1'b1};
      vecs[8]  = '{1'b0, 4'b1001, 32'hC300_003C, 0, 8'h3C, 1'b1};
      vecs[9]  = '{1'b0, 4'b0001, 32'h0000_0096, 0, 8'h96, 1'b1};
      vecs[10] = '{1'b0, 4'b0001, 32'h0000_0096, 0, 8'h96, 1'b1};

      @(negedge clk);
      for (int i = 0; i < 11; i++) begin
         if (vecs[i].do_reset) doReset();
         applyStimulus(vecs[i].valid, vecs[i].data, $sformatf("v%0d", i), ok);
         if (ok) begin
            waitTransfer(vecs[i].exp_win, vecs[i].chk_gap, $sformatf("v%0d", i));
            runFrame(vecs[i].exp_byte, -1, 4'b0000, 32'h0, $sformatf("v%0d", i));
         end
      end

      // Source data changes mid-frame and valid drops; the line keeps the latched byte.
      doReset();
      applyStimulus(4'b0001, 32'h0000_000F, "chg", ok);
      if (ok) begin
         waitTransfer(0, 1'b0, "chg");
         runFrame(8'h0F, 30, 4'b0000, 32'h0000_00F0, "chg");
         repeat (20) @(negedge clk);
         checkOutput("chg_after_busy", 32'(busy), 32'd0);
         checkOutput("chg_after_tx", 32'(tx), 32'd1);
      end

      // Reset lands in DATA bit 4 (a zero bit) and clears the pointer back to source 0.
      doReset();
      applyStimulus(4'b0001, 32'h0000_000F, "mrst", ok);
      if (ok) begin
         waitTransfer(0, 1'b0, "mrst");
         repeat (55) @(negedge clk);
         checkOutput("mrst_pre_tx", 32'(tx), 32'd0);
         checkOutput("mrst_pre_busy", 32'(busy), 32'd1);
         #2 rst = 1'b0;
         #1;
         checkOutput("mrst_async_tx", 32'(tx), 32'd1);
         checkOutput("mrst_async_busy", 32'(busy), 32'd0);
         checkOutput("mrst_async_ready", 32'(bus.req_ready), 32'd0);
         bus.req_valid = 4'b0011;
         bus.req_data  = 32'h0000_AA55;
         repeat (2) @(negedge clk);
         rst = 1'b1;
         applyStimulus(4'b0011, 32'h0000_AA55, "mrst2", ok);
         if (ok) begin
            waitTransfer(0, 1'b0, "mrst2");
            runFrame(8'h55, -1, 4'b0000, 32'h0, "mrst2");
         end
      end

      // Long idle with nothing valid.
      doReset();
      bad_tx = 0;
      bad_busy = 0;
      bad_rdy = 0;
      for (int c = 0; c < 500; c++) begin
         #1;
         if (tx !== 1'b1) bad_tx++;
         if (busy !== 1'b0) bad_busy++;
         if (bus.req_ready !== '0) bad_rdy++;
         @(negedge clk);
      end
      checkOutput("idle_tx", 32'(bad_tx), 32'd0);
      checkOutput("idle_busy", 32'(bad_busy), 32'd0);
      checkOutput("idle_ready", 32'(bad_rdy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
